// File: rtl/gate_sweep_checker_if.sv
// Bundles the stimulus/response and result signals between a gate sweep
// checker (slave) and whatever drives start/op_sel and returns the gate output (master).
interface gate_sweep_checker_if #(
    parameter int N_IN = 2
);
    logic                   start;
    logic [1:0]             op_sel;
    logic [N_IN-1:0]        stim;
    logic                   dut_out;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_cnt;
    logic [(1<<N_IN)-1:0]   fail_vec;

    modport master (
        output start, op_sel, dut_out,
        input  stim, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        input  start, op_sel, dut_out,
        output stim, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep of an N_IN-input combinational gate: drives each vector in
// ascending order, holds it SETTLE+1 cycles, samples and scores the gate output.
module gate_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input logic                 clk,
    input logic                 rst,
    gate_sweep_checker_if.slave sweep_if
);
    localparam int         NVEC     = 1 << N_IN;
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [N_IN-1:0]  stim_q;
    logic [3:0]       settle_q;
    logic [N_IN:0]    err_cnt_q;
    logic [NVEC-1:0]  fail_vec_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic             mismatch_d;
    logic [N_IN:0]    err_cnt_d;

    function automatic logic expected(input logic [N_IN-1:0] v, input logic [1:0] op);
        case (op)
            2'd0:    return &v;
            2'd1:    return |v;
            2'd2:    return ^v;
            default: return ~&v;
        endcase
    endfunction

    // Only meaningful on the sampling edge; elsewhere the FSM ignores it.
    always_comb begin
        mismatch_d = (sweep_if.dut_out != expected(stim_q, op_q));
        err_cnt_d  = err_cnt_q + {{N_IN{1'b0}}, mismatch_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 2'd0;
            stim_q     <= '0;
            settle_q   <= 4'd0;
            err_cnt_q  <= '0;
            fail_vec_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    stim_q <= '0;
                    done_q <= 1'b0;
                    if (sweep_if.start) begin
                        op_q       <= sweep_if.op_sel;
                        err_cnt_q  <= '0;
                        fail_vec_q <= '0;
                        pass_q     <= 1'b0;
                        settle_q   <= 4'd0;
                        busy_q     <= 1'b1;
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_q < SETTLE_C) begin
                        settle_q <= settle_q + 4'd1;
                    end else begin
                        settle_q  <= 4'd0;
                        err_cnt_q <= err_cnt_d;
                        if (mismatch_d)
                            fail_vec_q[stim_q] <= 1'b1;
                        if (stim_q != {N_IN{1'b1}}) begin
                            stim_q <= stim_q + 1'b1;
                        end else begin
                            // Verdict uses the count including this final vector.
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == '0);
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    stim_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sweep_if.stim     = stim_q;
    assign sweep_if.busy     = busy_q;
    assign sweep_if.done     = done_q;
    assign sweep_if.pass     = pass_q;
    assign sweep_if.err_cnt  = err_cnt_q;
    assign sweep_if.fail_vec = fail_vec_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: table of full sweeps on a SETTLE=2
// instance, plus held-start, async-reset and SETTLE=0 sequences.
module tb_gate_sweep_checker;
    logic clk = 1'b0;
    logic rst;
    logic tie1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    gate_sweep_checker_if #(.N_IN(2)) bus_a ();
    gate_sweep_checker_if #(.N_IN(2)) bus_b ();

    // Gate models: AND gate, or output tied high when tie1 is set.
    assign bus_a.dut_out = tie1 ? 1'b1 : (bus_a.stim[1] & bus_a.stim[0]);
    assign bus_b.dut_out = bus_b.stim[1] & bus_b.stim[0];

    gate_sweep_checker #(.N_IN(2), .SETTLE(2)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .sweep_if (bus_a.slave)
    );

    gate_sweep_checker #(.N_IN(2), .SETTLE(0)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .sweep_if (bus_b.slave)
    );

    typedef struct {
        string      name;
        logic [1:0] op;
        logic       tie;
        int         err;
        logic [3:0] fail;
        logic       pass;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Full sweep on instance A starting from IDLE; checks trace, done timing and results.
    task automatic sweep_a(input string name, input logic [1:0] op, input logic tie,
                           input int exp_err, input logic [3:0] exp_fail, input logic exp_pass);
        tie1 = tie;
        bus_a.op_sel = op;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk({name, " trace"}, {bus_a.busy, bus_a.done, bus_a.stim}, {1'b1, 1'b0, 2'(c / 3)});
            @(posedge clk); #1;
        end
        chk({name, " done"}, {bus_a.done, bus_a.busy}, 2'b10);
        chk({name, " err_cnt"}, bus_a.err_cnt, exp_err);
        chk({name, " fail_vec"}, bus_a.fail_vec, exp_fail);
        chk({name, " pass"}, bus_a.pass, exp_pass);
        @(posedge clk); #1;
        chk({name, " idle"}, {bus_a.done, bus_a.busy, bus_a.stim, bus_a.err_cnt, bus_a.pass},
            {1'b0, 1'b0, 2'd0, 3'(exp_err), exp_pass});
        $display("sweep %s op=%0d err=%0d fail=%b pass=%0b", name, op,
                 bus_a.err_cnt, bus_a.fail_vec, bus_a.pass);
    endtask

    initial begin
        int dones;
        tbl[0] = '{"and_and",  2'd0, 1'b0, 0, 4'b0000, 1'b1};
        tbl[1] = '{"and_or",   2'd1, 1'b0, 2, 4'b0110, 1'b0};
        tbl[2] = '{"one_nand", 2'd3, 1'b1, 1, 4'b1000, 1'b0};
        tbl[3] = '{"and_xor",  2'd2, 1'b0, 3, 4'b1110, 1'b0};
        tbl[4] = '{"one_or",   2'd1, 1'b1, 1, 4'b0001, 1'b0};

        rst = 1'b1;
        tie1 = 1'b0;
        bus_a.start = 1'b0; bus_a.op_sel = 2'd0;
        bus_b.start = 1'b0; bus_b.op_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_cnt, bus_a.fail_vec}, 0);
        chk("reset_b", {bus_b.stim, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_cnt, bus_b.fail_vec}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            sweep_a(tbl[i].name, tbl[i].op, tbl[i].tie, tbl[i].err, tbl[i].fail, tbl[i].pass);

        // start held high: two back-to-back sweeps, op_sel changes mid-sweep ignored
        tie1 = 1'b0;
        bus_a.op_sel = 2'd0;
        bus_a.start = 1'b1;
        dones = 0;
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus_a.done) dones++;
            case (c)
                12: chk("held s1 done", {bus_a.done, bus_a.err_cnt, bus_a.pass}, {1'b1, 3'd0, 1'b1});
                13: chk("held done->idle", {bus_a.done, bus_a.busy}, 2'b00);
                14: chk("held s2 start", {bus_a.busy, bus_a.pass, bus_a.err_cnt, bus_a.stim}, {1'b1, 1'b0, 3'd0, 2'd0});
                26: chk("held s2 done", {bus_a.done, bus_a.err_cnt, bus_a.fail_vec, bus_a.pass},
                        {1'b1, 3'd2, 4'b0110, 1'b0});
                default: ;
            endcase
            if (c == 5)  bus_a.op_sel = 2'd1;
            if (c == 16) bus_a.op_sel = 2'd2;
            if (c == 27) bus_a.start = 1'b0;
        end
        chk("held done pulses", dones, 2);
        $display("held-start sequence: done pulses=%0d", dones);

        // async reset while stim=2
        bus_a.op_sel = 2'd0;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre-rst stim", bus_a.stim, 2);
        #2 rst = 1'b1;
        #1;
        chk("async rst outputs", {bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_cnt, bus_a.fail_vec}, 0);
        #2 rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus_a.done || bus_a.busy) dones++;
        end
        chk("post-rst quiet", dones, 0);
        $display("reset sequence: activity cycles after reset=%0d", dones);
        sweep_a("after_rst", 2'd0, 1'b0, 0, 4'b0000, 1'b1);

        // SETTLE=0 instance: one cycle per vector, done after E4
        bus_b.op_sel = 2'd0;
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("s0 trace", {bus_b.busy, bus_b.done, bus_b.stim}, {1'b1, 1'b0, 2'(c)});
            @(posedge clk); #1;
        end
        chk("s0 done", {bus_b.done, bus_b.busy, bus_b.pass, bus_b.err_cnt, bus_b.fail_vec},
            {1'b1, 1'b0, 1'b1, 3'd0, 4'b0000});
        $display("settle0 sweep err=%0d pass=%0b", bus_b.err_cnt, bus_b.pass);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
